// File: rtl/setup_ddr_preload.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : setup_ddr_preload                                                |
// | Brief   : Copies NUM_BEATS beats from a word-wide source table into DDR    |
// |           over Avalon-MM once calibration completes. Defining              |
// |           SETUP_DDR_VERIFY_EN adds a read-back and compare pass.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module setup_ddr_preload #(
    parameter int DATA_W    = 256,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 25,
    parameter int NUM_BEATS = 4,
    parameter int DDR_BASE  = 0,
    parameter int SRC_AW    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cal_success,
    output logic [SRC_AW-1:0]   src_addr,
    input  logic [WORD_W-1:0]   src_data,
    output logic [ADDR_W-1:0]   amm_addr,
    output logic [DATA_W-1:0]   amm_writedata,
    output logic                amm_write,
    output logic                amm_read,
    output logic [DATA_W/8-1:0] amm_byteenable,
    output logic [6:0]          amm_burstcount,
    input  logic                amm_ready,
    input  logic [DATA_W-1:0]   amm_readdata,
    input  logic                amm_readdatavalid,
    output logic                setup_done,
    output logic                setup_error,
    output logic [SRC_AW-1:0]   beat_count
);

    localparam int                c_WPB       = DATA_W / WORD_W;
    localparam int                c_KW        = $clog2(c_WPB + 1);
    localparam logic [c_KW-1:0]   c_K_LAST    = c_KW'(c_WPB);
    localparam logic [c_KW-1:0]   c_K_STOP    = c_KW'(c_WPB - 1);
    localparam logic [SRC_AW-1:0] c_WPB_A     = SRC_AW'(c_WPB);
    localparam logic [SRC_AW-1:0] c_LAST_BEAT = SRC_AW'(NUM_BEATS - 1);
    localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(DDR_BASE);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_FETCH       = 3'd1;
    localparam logic [2:0] c_WRITE       = 3'd2;
    localparam logic [2:0] c_DONE        = 3'd5;
`ifdef SETUP_DDR_VERIFY_EN
    localparam logic [2:0] c_VERIFY_RD   = 3'd3;
    localparam logic [2:0] c_VERIFY_WAIT = 3'd4;
`endif

    logic [2:0]        r_state;
    logic [c_KW-1:0]   r_k;
    logic [DATA_W-1:0] r_buf;
    logic [SRC_AW-1:0] r_src_addr;
    logic [ADDR_W-1:0] r_amm_addr;
    logic [DATA_W-1:0] r_amm_writedata;
    logic              r_amm_write;
    logic              r_setup_done;
    logic [SRC_AW-1:0] r_beat_count;
    logic [DATA_W-1:0] w_beat;
    logic              w_abort;
`ifdef SETUP_DDR_VERIFY_EN
    logic              r_amm_read;
    logic              r_setup_error;
    logic [SRC_AW-1:0] r_vbeat;
`endif

    // Words arrive lowest-first, so shifting in from the top leaves word k at slot k.
    generate
        if (c_WPB == 1) begin : g_single_word
            assign w_beat = src_data;
        end else begin : g_multi_word
            assign w_beat = {src_data, r_buf[DATA_W-1:WORD_W]};
        end
    endgenerate

    assign w_abort = !cal_success && (r_state != c_IDLE) && (r_state != c_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_k             <= '0;
            r_buf           <= '0;
            r_src_addr      <= '0;
            r_amm_addr      <= '0;
            r_amm_writedata <= '0;
            r_amm_write     <= 1'b0;
            r_setup_done    <= 1'b0;
            r_beat_count    <= '0;
`ifdef SETUP_DDR_VERIFY_EN
            r_amm_read      <= 1'b0;
            r_setup_error   <= 1'b0;
            r_vbeat         <= '0;
`endif
        end else if (w_abort) begin
            r_state      <= c_IDLE;
            r_beat_count <= '0;
            r_amm_write  <= 1'b0;
`ifdef SETUP_DDR_VERIFY_EN
            r_amm_read   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cal_success) begin
                        r_state      <= c_FETCH;
                        r_k          <= '0;
                        r_src_addr   <= '0;
                        r_beat_count <= '0;
                    end
                end
                c_FETCH: begin
                    if (r_k != '0) r_buf <= w_beat;
                    if (r_k < c_K_STOP) r_src_addr <= r_src_addr + 1'b1;
                    if (r_k == c_K_LAST) begin
                        r_amm_writedata <= w_beat;
                        r_amm_addr      <= c_BASE + ADDR_W'(r_beat_count);
                        r_amm_write     <= 1'b1;
                        r_state         <= c_WRITE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                c_WRITE: begin
                    if (amm_ready) begin
                        r_amm_write  <= 1'b0;
                        r_beat_count <= r_beat_count + 1'b1;
                        r_k          <= '0;
                        if (r_beat_count == c_LAST_BEAT) begin
`ifdef SETUP_DDR_VERIFY_EN
                            r_state    <= c_VERIFY_RD;
                            r_vbeat    <= '0;
                            r_src_addr <= '0;
`else
                            r_state      <= c_DONE;
                            r_setup_done <= 1'b1;
`endif
                        end else begin
                            r_state    <= c_FETCH;
                            r_src_addr <= (r_beat_count + 1'b1) * c_WPB_A;
                        end
                    end
                end
`ifdef SETUP_DDR_VERIFY_EN
                // Re-fetch the source beat first, then hold the read until accepted.
                c_VERIFY_RD: begin
                    if (!r_amm_read) begin
                        if (r_k != '0) r_buf <= w_beat;
                        if (r_k < c_K_STOP) r_src_addr <= r_src_addr + 1'b1;
                        if (r_k == c_K_LAST) begin
                            r_amm_addr <= c_BASE + ADDR_W'(r_vbeat);
                            r_amm_read <= 1'b1;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end else if (amm_ready) begin
                        r_amm_read <= 1'b0;
                        r_state    <= c_VERIFY_WAIT;
                    end
                end
                c_VERIFY_WAIT: begin
                    if (amm_readdatavalid) begin
                        if (amm_readdata != r_buf) r_setup_error <= 1'b1;
                        r_k <= '0;
                        if (r_vbeat == c_LAST_BEAT) begin
                            r_state      <= c_DONE;
                            r_setup_done <= 1'b1;
                        end else begin
                            r_vbeat    <= r_vbeat + 1'b1;
                            r_src_addr <= (r_vbeat + 1'b1) * c_WPB_A;
                            r_state    <= c_VERIFY_RD;
                        end
                    end
                end
`endif
                c_DONE: begin
                    r_amm_write  <= 1'b0;
                    r_setup_done <= 1'b1;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign src_addr       = r_src_addr;
    assign amm_addr       = r_amm_addr;
    assign amm_writedata  = r_amm_writedata;
    assign amm_write      = r_amm_write;
    assign amm_byteenable = '1;
    assign amm_burstcount = 7'd1;
    assign setup_done     = r_setup_done;
    assign beat_count     = r_beat_count;
`ifdef SETUP_DDR_VERIFY_EN
    assign amm_read       = r_amm_read;
    assign setup_error    = r_setup_error;
`else
    logic w_unused_rd;
    assign w_unused_rd    = ^{amm_readdata, amm_readdatavalid};
    assign amm_read       = 1'b0;
    assign setup_error    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_setup_ddr_preload.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_setup_ddr_preload                                             |
// | Brief   : Directed self-checking bench for setup_ddr_preload (default      |
// |           instance plus a 2-beat instance based at the top of DDR).        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_setup_ddr_preload;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         corrupt = 1'b0;
    int           checks = 0;
    int           errors = 0;
    logic         both_seen = 1'b0;

    // default instance
    logic         cal_success = 1'b0;
    logic [9:0]   src_addr;
    logic [31:0]  src_data = '0;
    logic [24:0]  amm_addr;
    logic [255:0] amm_writedata;
    logic         amm_write, amm_read;
    logic [31:0]  amm_byteenable;
    logic [6:0]   amm_burstcount;
    logic         amm_ready = 1'b1;
    logic [255:0] amm_readdata = '0;
    logic         amm_readdatavalid = 1'b0;
    logic         setup_done, setup_error;
    logic [9:0]   beat_count;

    // top-of-memory instance
    logic         x_cal = 1'b0;
    logic [9:0]   x_src_addr;
    logic [31:0]  x_src_data = '0;
    logic [24:0]  x_amm_addr;
    logic [255:0] x_amm_writedata;
    logic         x_amm_write, x_amm_read;
    logic [31:0]  x_amm_byteenable;
    logic [6:0]   x_amm_burstcount;
    logic [255:0] x_amm_readdata = '0;
    logic         x_amm_readdatavalid = 1'b0;
    logic         x_setup_done, x_setup_error;
    logic [9:0]   x_beat_count;

    setup_ddr_preload dut (
        .clk(clk), .reset(reset), .cal_success(cal_success),
        .src_addr(src_addr), .src_data(src_data),
        .amm_addr(amm_addr), .amm_writedata(amm_writedata),
        .amm_write(amm_write), .amm_read(amm_read),
        .amm_byteenable(amm_byteenable), .amm_burstcount(amm_burstcount),
        .amm_ready(amm_ready), .amm_readdata(amm_readdata),
        .amm_readdatavalid(amm_readdatavalid),
        .setup_done(setup_done), .setup_error(setup_error), .beat_count(beat_count)
    );

    setup_ddr_preload #(.DDR_BASE(32'h01FF_FFFF), .NUM_BEATS(2)) dut_wrap (
        .clk(clk), .reset(reset), .cal_success(x_cal),
        .src_addr(x_src_addr), .src_data(x_src_data),
        .amm_addr(x_amm_addr), .amm_writedata(x_amm_writedata),
        .amm_write(x_amm_write), .amm_read(x_amm_read),
        .amm_byteenable(x_amm_byteenable), .amm_burstcount(x_amm_burstcount),
        .amm_ready(1'b1), .amm_readdata(x_amm_readdata),
        .amm_readdatavalid(x_amm_readdatavalid),
        .setup_done(x_setup_done), .setup_error(x_setup_error), .beat_count(x_beat_count)
    );

    // Source table: word i holds i+1, returned one cycle after the address.
    always @(posedge clk) begin
        src_data   <= 32'(src_addr) + 32'd1;
        x_src_data <= 32'(x_src_addr) + 32'd1;
    end

    logic [24:0]  wr_addr_log [0:15];
    logic [255:0] wr_data_log [0:15];
    int           wr_count = 0;
    int           rd_count = 0;
    logic [255:0] mem [logic [24:0]];
    logic [24:0]  x_addr_log [0:15];
    logic [255:0] x_data_log [0:15];
    int           x_wr_count = 0;
    logic [255:0] x_mem [logic [24:0]];

    always @(posedge clk) begin
        amm_readdatavalid   <= 1'b0;
        x_amm_readdatavalid <= 1'b0;
        if (!reset && amm_write && amm_ready) begin
            if (wr_count < 16) begin
                wr_addr_log[wr_count] = amm_addr;
                wr_data_log[wr_count] = amm_writedata;
            end
            wr_count++;
            mem[amm_addr] = amm_writedata;
        end
        if (!reset && amm_read && amm_ready) begin
            amm_readdatavalid <= 1'b1;
            amm_readdata <= (mem.exists(amm_addr) ? mem[amm_addr] : 256'd0)
                          ^ ((corrupt && amm_addr == 25'd3) ? 256'd1 : 256'd0);
            rd_count++;
        end
        if (!reset && x_amm_write) begin
            if (x_wr_count < 16) begin
                x_addr_log[x_wr_count] = x_amm_addr;
                x_data_log[x_wr_count] = x_amm_writedata;
            end
            x_wr_count++;
            x_mem[x_amm_addr] = x_amm_writedata;
        end
        if (!reset && x_amm_read) begin
            x_amm_readdatavalid <= 1'b1;
            x_amm_readdata <= x_mem.exists(x_amm_addr) ? x_mem[x_amm_addr] : 256'd0;
        end
    end

    always @(negedge clk) if (amm_write && amm_read) both_seen = 1'b1;

    function automatic logic [255:0] exp_beat(input int b);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(b * 8 + k + 1);
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1; cal_success = 1'b0; x_cal = 1'b0; amm_ready = 1'b1; corrupt = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wr_count = 0; rd_count = 0; x_wr_count = 0;
        mem.delete(); x_mem.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({amm_write, amm_read, setup_done, setup_error} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {amm_write, amm_read, setup_done, setup_error});
        end
        checks++;
        if ({beat_count, src_addr, amm_addr} !== 45'd0) begin
            errors++; $display("FAIL reset_counts: got beat=%0d src=%0d addr=%0h expected 0", beat_count, src_addr, amm_addr);
        end
        checks++;
        if (amm_writedata !== 256'd0) begin
            errors++; $display("FAIL reset_wdata: got %h expected 0", amm_writedata);
        end
        checks++;
        if (amm_byteenable !== 32'hFFFF_FFFF || amm_burstcount !== 7'd1) begin
            errors++; $display("FAIL static_ports: got be=%h bc=%0d expected ffffffff/1", amm_byteenable, amm_burstcount);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (amm_write !== 1'b0 || src_addr !== 10'd0 || wr_count != 0) begin
            errors++; $display("FAIL idle_hold: got write=%b src=%0d writes=%0d expected 0/0/0", amm_write, src_addr, wr_count);
        end
    endtask

    task automatic test_basic();
        int first = 0;
        int n = 0;
        logic [9:0]   s0 = '0, s7 = '0;
        logic [255:0] c0;
        c0 = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        do_reset();
        cal_success = 1'b1;
        while (!setup_done && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) s0 = src_addr;
            if (n == 8) s7 = src_addr;
            if (amm_write && first == 0) first = n;
        end
        checks++;
        if (setup_done !== 1'b1) begin errors++; $display("FAIL basic_timeout: got done=%b expected 1", setup_done); end
        checks++;
        if (s0 !== 10'd0 || s7 !== 10'd7) begin
            errors++; $display("FAIL fetch_addr: got %0d/%0d expected 0/7", s0, s7);
        end
        checks++;
        if (first != 10) begin errors++; $display("FAIL first_write_latency: got %0d expected 10", first); end
        checks++;
        if (wr_count != 4) begin errors++; $display("FAIL basic_writes: got %0d expected 4", wr_count); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr_log[i] !== 25'(i)) begin
                errors++; $display("FAIL basic_addr%0d: got %0h expected %0h", i, wr_addr_log[i], i);
            end
        end
        checks++;
        if (wr_data_log[0] !== c0) begin errors++; $display("FAIL beat0_data: got %h expected %h", wr_data_log[0], c0); end
        checks++;
        if (wr_data_log[3] !== exp_beat(3)) begin
            errors++; $display("FAIL beat3_data: got %h expected %h", wr_data_log[3], exp_beat(3));
        end
        checks++;
        if (beat_count !== 10'd4 || setup_error !== 1'b0) begin
            errors++; $display("FAIL basic_final: got beat=%0d err=%b expected 4/0", beat_count, setup_error);
        end
`ifdef SETUP_DDR_VERIFY_EN
        checks++;
        if (rd_count != 4) begin errors++; $display("FAIL basic_reads: got %0d expected 4", rd_count); end
`endif
        cal_success = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (setup_done !== 1'b1 || amm_write !== 1'b0 || amm_read !== 1'b0 || wr_count != 4) begin
            errors++; $display("FAIL done_sticky: got done=%b wr=%b rd=%b writes=%0d expected 1/0/0/4", setup_done, amm_write, amm_read, wr_count);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        do_reset();
        cal_success = 1'b1;
        while (!(amm_write && amm_addr == 25'd2) && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!(amm_write && amm_addr == 25'd2)) begin errors++; $display("FAIL stall_find: got addr=%0h expected write to 2", amm_addr); end
        amm_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (amm_write !== 1'b1 || amm_addr !== 25'd2 || amm_writedata !== exp_beat(2) || wr_count != 2) begin
                errors++; $display("FAIL stall_hold%0d: got wr=%b addr=%0h writes=%0d expected 1/2/2", c, amm_write, amm_addr, wr_count);
            end
        end
        amm_ready = 1'b1;
        n = 0;
        while (!setup_done && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (wr_count != 4 || wr_addr_log[2] !== 25'd2 || wr_addr_log[3] !== 25'd3) begin
            errors++; $display("FAIL stall_total: got writes=%0d addr2=%0h expected 4/2", wr_count, wr_addr_log[2]);
        end
    endtask

    task automatic test_cal_drop();
        int n = 0;
        do_reset();
        cal_success = 1'b1;
        while (wr_count < 2 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (beat_count !== 10'd2) begin errors++; $display("FAIL drop_pre: got beat=%0d expected 2", beat_count); end
        cal_success = 1'b0;
        @(negedge clk);
        checks++;
        if (beat_count !== 10'd0 || amm_write !== 1'b0) begin
            errors++; $display("FAIL drop_clear: got beat=%0d wr=%b expected 0/0", beat_count, amm_write);
        end
        wr_count = 0;
        repeat (3) @(negedge clk);
        cal_success = 1'b1;
        n = 0;
        while (!setup_done && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (wr_count != 4 || wr_addr_log[0] !== 25'd0 || wr_addr_log[3] !== 25'd3 || beat_count !== 10'd4) begin
            errors++; $display("FAIL drop_restart: got writes=%0d first=%0h beat=%0d expected 4/0/4", wr_count, wr_addr_log[0], beat_count);
        end
        checks++;
        if (wr_data_log[0] !== exp_beat(0)) begin errors++; $display("FAIL drop_data: got %h expected %h", wr_data_log[0], exp_beat(0)); end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        do_reset();
        amm_ready = 1'b0;
        cal_success = 1'b1;
        while (!amm_write && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (amm_write !== 1'b1) begin errors++; $display("FAIL midwr_setup: got wr=%b expected 1", amm_write); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (amm_write !== 1'b0 || setup_done !== 1'b0 || beat_count !== 10'd0 || amm_addr !== 25'd0 || wr_count != 0) begin
            errors++; $display("FAIL midwr_reset: got wr=%b done=%b beat=%0d addr=%0h writes=%0d expected 0", amm_write, setup_done, beat_count, amm_addr, wr_count);
        end
        reset = 1'b0;
        amm_ready = 1'b1;
    endtask

    task automatic test_wrap();
        int n = 0;
        do_reset();
        x_cal = 1'b1;
        while (!x_setup_done && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (x_setup_done !== 1'b1 || x_wr_count != 2 || x_beat_count !== 10'd2) begin
            errors++; $display("FAIL wrap_count: got done=%b writes=%0d beat=%0d expected 1/2/2", x_setup_done, x_wr_count, x_beat_count);
        end
        checks++;
        if (x_addr_log[0] !== 25'h1FF_FFFF || x_addr_log[1] !== 25'h000_0000) begin
            errors++; $display("FAIL wrap_addr: got %h,%h expected 1ffffff,0000000", x_addr_log[0], x_addr_log[1]);
        end
        checks++;
        if (x_setup_error !== 1'b0 || x_data_log[1] !== exp_beat(1)) begin
            errors++; $display("FAIL wrap_data: got err=%b data=%h expected 0/%h", x_setup_error, x_data_log[1], exp_beat(1));
        end
    endtask

`ifdef SETUP_DDR_VERIFY_EN
    task automatic test_verify();
        int n = 0;
        do_reset();
        corrupt = 1'b1;
        cal_success = 1'b1;
        while (!setup_done && n < 600) begin @(negedge clk); n++; end
        checks++;
        if (rd_count != 4 || wr_count != 4) begin
            errors++; $display("FAIL verify_reads: got reads=%0d writes=%0d expected 4/4", rd_count, wr_count);
        end
        checks++;
        if (setup_error !== 1'b1 || setup_done !== 1'b1) begin
            errors++; $display("FAIL verify_error: got err=%b done=%b expected 1/1", setup_error, setup_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_cal_drop();
        test_reset_mid_write();
        test_wrap();
`ifdef SETUP_DDR_VERIFY_EN
        test_verify();
`endif
        checks++;
        if (both_seen !== 1'b0) begin errors++; $display("FAIL rd_wr_exclusive: got %b expected 0", both_seen); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
